// File: rtl/pixel_cache_pkg.sv
// Shared constants, FSM states and line layout for the pixel cache.
// Frame is 640x480 at 1 bit per pixel, packed 16 pixels per word.
package pixel_cache_pkg;

  localparam int unsigned FRAME_W       = 640;
  localparam int unsigned FRAME_H       = 480;
  localparam int unsigned WORD_PIX      = 16;
  localparam int unsigned WORDS_PER_ROW = 40;
  localparam int unsigned ADDR_W        = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESPOND
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   tag;
    logic [WORD_PIX-1:0] data;
  } line_t;

  // y*40 + x/16, built from shifts
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [9:0] px,
    input logic [9:0] py
  );
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(py);
    return (yw << 5) + (yw << 3) + ADDR_W'(px[9:4]);
  endfunction

endpackage

// File: rtl/pixel_line_store.sv
// Direct-mapped line storage: valid bits with async clear,
// tag/data arrays, and a registered read port.
module pixel_line_store
  import pixel_cache_pkg::*;
#(
  parameter int LINES = 8,
  localparam int IW = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IW-1:0]       idx,
  input  logic                rd_en,
  output line_t               rd_line,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_tag,
  input  logic [WORD_PIX-1:0] wr_data,
  input  logic                set_valid,
  input  logic                clr
);

  logic [LINES-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   tag_mem  [LINES];
  logic [WORD_PIX-1:0] data_mem [LINES];
  line_t               rd_q, rd_d;

  always_comb begin
    valid_d = valid_q;
    if (set_valid) valid_d[idx] = 1'b1;
    // a clear on the same edge wins over a fill
    if (clr) valid_d = '0;
    rd_d = rd_q;
    if (rd_en) rd_d = {valid_q[idx], tag_mem[idx], data_mem[idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end

  assign rd_line = rd_q;

endmodule

// File: rtl/pixel_cache.sv
// Pixel-read responder: direct-mapped line cache in front of the
// packed 1-bit frame buffer; misses fetch one 16-pixel word.
module pixel_cache
  import pixel_cache_pkg::*;
#(
  parameter int LINES  = 8,
  parameter int MEM_AW = ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                request,
  output logic                pixel,
  output logic                ready,
  input  logic                invalidate,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [WORD_PIX-1:0] mem_rdata,
  input  logic                mem_rvalid
);

  localparam int IW = $clog2(LINES);

  state_e            state_q, state_d;
  logic              lk_q, lk_d;
  logic              inv_q, inv_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              pixel_q, pixel_d;
  logic              ready_q, ready_d;
  logic              mem_rd_q, mem_rd_d;

  line_t             rd_line;
  logic [ADDR_W-1:0] tag;
  logic              rd_en, wr_en, set_v;
  logic              oor, hit, accept;

  assign tag    = ADDR_W'(addr_q >> IW);
  assign oor    = (x_q >= 10'(FRAME_W)) || (y_q >= 10'(FRAME_H));
  assign hit    = rd_line.valid && (rd_line.tag == tag)
               && !inv_q && !invalidate;
  assign accept = request
               && (state_q == IDLE || state_q == RESPOND);

  pixel_line_store #(.LINES(LINES)) u_store (
    .clk       (clk),
    .rst_n     (reset),
    .idx       (addr_q[IW-1:0]),
    .rd_en     (rd_en),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_tag    (tag),
    .wr_data   (mem_rdata),
    .set_valid (set_v),
    .clr       (invalidate)
  );

  always_comb begin
    state_d    = state_q;
    lk_d       = lk_q;
    inv_d      = inv_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    pixel_d    = 1'b0;
    ready_d    = 1'b0;
    mem_rd_d   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    set_v      = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOOKUP: begin
        inv_d = inv_q | invalidate;
        if (!lk_q) begin
          rd_en = 1'b1;
          lk_d  = 1'b1;
        end else if (oor) begin
          ready_d = 1'b1;
          state_d = RESPOND;
        end else if (hit) begin
          pixel_d = rd_line.data[x_q[3:0]];
          ready_d = 1'b1;
          state_d = RESPOND;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q;
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        inv_d   = inv_q | invalidate;
        state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        inv_d = inv_q | invalidate;
        if (mem_rvalid) begin
          wr_en   = 1'b1;
          // an invalidate seen mid-fetch leaves the line invalid
          set_v   = !inv_q;
          pixel_d = mem_rdata[x_q[3:0]];
          ready_d = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      x_d     = x;
      y_d     = y;
      addr_d  = MEM_AW'(word_addr(x, y));
      lk_d    = 1'b0;
      inv_d   = 1'b0;
      state_d = LOOKUP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lk_q       <= 1'b0;
      inv_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      pixel_q    <= 1'b0;
      ready_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_q       <= lk_d;
      inv_q      <= inv_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      pixel_q    <= pixel_d;
      ready_q    <= ready_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign pixel    = pixel_q;
  assign ready    = ready_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: doc/pixel_cache.md
# pixel_cache

Responder side of the pixel-read handshake used by the edge search units. It accepts a request for one binarized pixel at (x, y), serves it from a small direct-mapped line cache, and on a miss fetches the containing 16-pixel word from the packed 1-bit frame buffer. It sits between the edge search initiators and frame-buffer read port memory.

## Interface
- LINES, 8: number of cache lines; power of two, minimum 2.
- MEM_AW, 15: frame-buffer word-address width.
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- x, y  in  10 each  pixel coordinate; sampled only on the accept edge.
- request  in  1  pixel request from the initiator.
- pixel  out  1  pixel value; valid only while ready=1.
- ready  out  1  one-cycle response strobe.
- invalidate  in  1  one-cycle pulse at frame change; drops all cached lines.
- mem_addr  out  MEM_AW  word address; held stable from the mem_rd cycle until mem_rvalid.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  16  word data; bit i is the pixel at x = 16·word_col + i.
- mem_rvalid  in  1  one-cycle data strobe; latency of 1 or more cycles after mem_rd.

## Operation
- Frame: 640×480 pixels at 1 bit each, 40 words per row.
  - word address = y·40 + x[9:4], computed as (y<<5)+(y<<3)+x[9:4] at 15 bits.
  - bit select = x[3:0].
- Line index = addr[log2(LINES)-1:0]. Tag = the remaining upper address bits. Each line holds 1 valid bit, a tag and 16 data bits.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESPOND.
- IDLE:
  - A request is accepted on an edge where request=1. Register x and y, compute the address, go to LOOKUP.
- LOOKUP:
  - If x≥640 or y≥480: out of range; pixel=0, go to RESPOND, no memory access.
  - Else if the line is valid and the tag matches: hit; go to RESPOND.
  - Else: miss; go to MISS_REQ.
- MISS_REQ:
  - Assert mem_rd for one cycle with mem_addr, go to MISS_WAIT.
- MISS_WAIT:
  - On mem_rvalid, write data and tag to the line, set valid, select the bit, go to RESPOND.
  - mem_rvalid is ignored in every other state.
- RESPOND:
  - ready=1 and pixel is driven for exactly one cycle, then return to IDLE.
  - A request still high in IDLE is treated as a new request. Initiators drop request on the edge where they see ready.
- invalidate:
  - Clears all valid bits on that edge, in any state.
  - If asserted during MISS_WAIT, the fill still supplies the response, but the line is left invalid.
  - If asserted on the same edge as a LOOKUP, the lookup is a miss.
- Reset values: ready=0, pixel=0, mem_rd=0, mem_addr=0, FSM=IDLE, all valid bits 0.
  - Reset during MISS_WAIT abandons the fetch. A late mem_rvalid is ignored.

## Timing
- Accept edge E0 (IDLE, request=1) → LOOKUP during E0–E1.
- Hit or out-of-range: ready high in cycle E2–E3. Latency is 2 cycles.
- Miss:
  - mem_rd high in cycle E2–E3.
  - mem_rvalid sampled at edge Ev.
  - ready high in cycle Ev–Ev+1.
- Back-to-back: request held high gives a new accept at the edge that ends RESPOND. Hit throughput is 1 pixel per 3 cycles.
- All outputs are registered. There is no combinational path from request, x or y to any output.

## Structure
- pixel_cache_pkg holds:
  - FRAME_W=640, FRAME_H=480, WORD_PIX=16, WORDS_PER_ROW=40.
  - The address-width constant.
  - The state enum typedef.
  - The line struct typedef (valid, tag, data).
- Sub-module pixel_line_store: LINES-entry tag/data/valid arrays.
  - Ports: index, read, write (tag, data), per-entry valid set, global clear.
  - Uses the same async active-low reset for the valid bits.
- Top level: FSM, address arithmetic, bit select, memory handshake.

## Test plan
- Reset, then request (5,0). Bench memory has latency 3 and word 0=16'h0020.
  - mem_rd at E2 with mem_addr=0; ready 4 cycles later with pixel=1.
  - A second request (4,0) hits: pixel=0, ready at E2, no mem_rd.
- Request (639,479): mem_addr=19199, bit 15. Then request (640,10): ready at E2, pixel=0, no mem_rd.
- Conflict miss with LINES=8: request addresses 0, 8, 0.
  - Three mem_rd pulses.
  - Responses match the memory contents each time.
- Fill word 3 (hit confirmed), pulse invalidate, re-request word 3: mem_rd issued again.
  - Invalidate during MISS_WAIT: correct pixel returned; a repeat request misses.
- Assert reset while in MISS_WAIT, then drive mem_rvalid:
  - No ready.
  - All outputs 0.
  - The next request misses.
- Hold request high across 4 consecutive hits: ready pulses every 3 cycles with the correct pixels.
